// File: rtl/bus_source_encoder.sv
// Encodes one-hot bus source strobes to a registered mux select; 1-cycle latency; i_stall holds select/valid.
// Multi-driver requests are arbitrated (round-robin when BUS_RR_ARB_EN is defined, else lowest index) and counted.
module bus_source_encoder #(
    parameter int               NUM_SRC  = 24,
    parameter int               SEL_W    = 5,
    parameter logic [SEL_W-1:0] IDLE_SEL = 5'd31,
    parameter int               CNT_W    = 8
) (
    input  logic               i_clock,
    input  logic               i_clear,
    input  logic [NUM_SRC-1:0] i_src_out,
    input  logic               i_stall,
    input  logic               i_err_clr,
    output logic [SEL_W-1:0]   o_select,
    output logic               o_bus_valid,
    output logic               o_conflict,
    output logic               o_conflict_sticky,
    output logic [CNT_W-1:0]   o_conflict_cnt
);

    logic [SEL_W-1:0] r_select;
    logic             r_bus_valid;
    logic             r_conflict;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;

    logic             w_any;
    logic             w_multi;
    logic [SEL_W-1:0] w_win;

`ifdef BUS_RR_ARB_EN
    logic [SEL_W-1:0] r_ptr;
    logic             w_found;
    int               w_idx;
`endif

    always_comb begin
        w_any   = |i_src_out;
        // Clearing the lowest set bit leaves something only if two or more were set.
        w_multi = |(i_src_out & (i_src_out - NUM_SRC'(1)));
        w_win   = IDLE_SEL;
`ifdef BUS_RR_ARB_EN
        w_found = 1'b0;
        w_idx   = 0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_SRC) begin
                w_idx = w_idx - NUM_SRC;
            end
            if (!w_found && i_src_out[w_idx]) begin
                w_found = 1'b1;
                w_win   = SEL_W'(w_idx);
            end
        end
`else
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (i_src_out[k]) begin
                w_win = SEL_W'(k);
            end
        end
`endif
    end

    always_ff @(posedge i_clock) begin
        if (i_clear) begin
            r_select    <= IDLE_SEL;
            r_bus_valid <= 1'b0;
            r_conflict  <= 1'b0;
            r_sticky    <= 1'b0;
            r_cnt       <= '0;
`ifdef BUS_RR_ARB_EN
            r_ptr       <= SEL_W'(NUM_SRC - 1);
`endif
        end else begin
            if (!i_stall) begin
                r_select    <= w_any ? w_win : IDLE_SEL;
                r_bus_valid <= w_any;
`ifdef BUS_RR_ARB_EN
                if (w_any) begin
                    r_ptr <= w_win;
                end
`endif
            end
            r_conflict <= w_multi;
            // A conflict in the same cycle as err_clr is a fresh event and survives the clear.
            if (i_err_clr) begin
                r_sticky <= w_multi;
                r_cnt    <= w_multi ? CNT_W'(1) : '0;
            end else if (w_multi) begin
                r_sticky <= 1'b1;
                if (r_cnt != '1) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_select          = r_select;
    assign o_bus_valid       = r_bus_valid;
    assign o_conflict        = r_conflict;
    assign o_conflict_sticky = r_sticky;
    assign o_conflict_cnt    = r_cnt;

endmodule
